// File: rtl/mdio_pkg.sv
// Shared types for the Clause-45 MDIO transaction sequencer:
// cop codes, FSM states, request bundle and engine frame bundle.
package mdio_pkg;

    localparam logic [1:0] COP_ADDR  = 2'b00;
    localparam logic [1:0] COP_WR    = 2'b01;
    localparam logic [1:0] COP_RDINC = 2'b10;
    localparam logic [1:0] COP_RD    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_RUN,
        S_ADDR_WAIT,
        S_GAP,
        S_DATA_RUN,
        S_DATA_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  dev;
        logic [15:0] regad;
        logic [15:0] wdata;
    } req_t;

    typedef struct packed {
        logic [1:0]  cop;
        logic [4:0]  phy;
        logic [4:0]  dev;
        logic [15:0] data;
    } frame_t;

    function automatic frame_t addr_frame(req_t r);
        frame_t f;
        f.cop  = COP_ADDR;
        f.phy  = r.phy;
        f.dev  = r.dev;
        f.data = r.regad;
        return f;
    endfunction

    function automatic frame_t data_frame(req_t r);
        frame_t f;
        f.cop  = r.op;
        f.phy  = r.phy;
        f.dev  = r.dev;
        f.data = (r.op == COP_WR) ? r.wdata : 16'h0000;
        return f;
    endfunction

    function automatic logic needs_addr(logic [1:0] op, logic hit);
        return (op == COP_ADDR) ||
               (((op == COP_WR) || (op == COP_RD)) && !hit);
    endfunction

endpackage

// File: rtl/mdio_addr_cache.sv
// Last-address cache for the MDIO sequencer: lookup, load,
// read-increment tracking and flush.
module mdio_addr_cache (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush,
    input  logic        load,
    input  logic        incr,
    input  logic [4:0]  key_phy,
    input  logic [4:0]  key_dev,
    input  logic [15:0] key_reg,
    input  logic [4:0]  upd_phy,
    input  logic [4:0]  upd_dev,
    input  logic [15:0] upd_reg,
    output logic        hit
);

    logic        valid;
    logic [4:0]  c_phy;
    logic [4:0]  c_dev;
    logic [15:0] c_reg;

    assign hit = valid &&
                 (c_phy == key_phy) &&
                 (c_dev == key_dev) &&
                 (c_reg == key_reg);

    // A read-increment only keeps the entry if it hit the same PHY/device.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= 1'b0;
            c_phy <= '0;
            c_dev <= '0;
            c_reg <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            c_phy <= upd_phy;
            c_dev <= upd_dev;
            c_reg <= upd_reg;
        end else if (incr) begin
            if (valid && (c_phy == upd_phy) && (c_dev == upd_dev)) begin
                c_reg <= c_reg + 16'd1;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdio_c45_seq.sv
// Clause-45 sequencer: turns one register request into address and
// data frames for the MDIO engine and returns the read data.
module mdio_c45_seq
    import mdio_pkg::*;
#(
    parameter int GAP_CYCLES    = 4,
    parameter bit ADDR_CACHE_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [4:0]  req_phy_i,
    input  logic [4:0]  req_dev_i,
    input  logic [15:0] req_reg_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_rdata_o,
    output logic        eng_run_o,
    output logic [1:0]  eng_cop_o,
    output logic [4:0]  eng_phy_o,
    output logic [4:0]  eng_dev_o,
    output logic [15:0] eng_data_o,
    input  logic        eng_busy_i,
    input  logic [15:0] eng_data_i,
    input  logic        cache_flush_i
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state;
    req_t             req;
    req_t             req_in;
    frame_t           frm;
    logic             busy_seen;
    logic [GAP_W-1:0] gap_cnt;
    logic             cache_hit;
    logic             hit;
    logic             need_addr;
    logic             busy_fell;
    logic             cache_load;
    logic             cache_incr;

    assign req_in.op    = req_op_i;
    assign req_in.phy   = req_phy_i;
    assign req_in.dev   = req_dev_i;
    assign req_in.regad = req_reg_i;
    assign req_in.wdata = req_wdata_i;

    // A flush in the accept cycle overrides the hit.
    assign hit        = ADDR_CACHE_EN && cache_hit && !cache_flush_i;
    assign need_addr  = needs_addr(req_op_i, hit);
    assign busy_fell  = busy_seen && !eng_busy_i;
    assign cache_load = (state == S_ADDR_WAIT) && busy_fell;
    assign cache_incr = (state == S_DATA_WAIT) && busy_fell &&
                        (req.op == COP_RDINC);

    assign eng_cop_o  = frm.cop;
    assign eng_phy_o  = frm.phy;
    assign eng_dev_o  = frm.dev;
    assign eng_data_o = frm.data;

    mdio_addr_cache u_cache (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush   (cache_flush_i),
        .load    (cache_load),
        .incr    (cache_incr),
        .key_phy (req_phy_i),
        .key_dev (req_dev_i),
        .key_reg (req_reg_i),
        .upd_phy (req.phy),
        .upd_dev (req.dev),
        .upd_reg (req.regad),
        .hit     (cache_hit)
    );

    // Strobes are only issued while the engine is idle, so a frame left
    // running across a reset is never overlapped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            req         <= '0;
            frm         <= '0;
            eng_run_o   <= 1'b0;
            busy_seen   <= 1'b0;
            gap_cnt     <= '0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_ready_o && req_valid_i) begin
                        req_ready_o <= 1'b0;
                        req         <= req_in;
                        state       <= need_addr ? S_ADDR_RUN : S_DATA_RUN;
                        if (!eng_busy_i) begin
                            eng_run_o <= 1'b1;
                            frm       <= need_addr ? addr_frame(req_in)
                                                   : data_frame(req_in);
                        end
                    end
                end
                S_ADDR_RUN, S_DATA_RUN: begin
                    if (eng_run_o) begin
                        eng_run_o <= 1'b0;
                        busy_seen <= 1'b0;
                        state     <= (state == S_ADDR_RUN) ? S_ADDR_WAIT
                                                           : S_DATA_WAIT;
                    end else if (!eng_busy_i) begin
                        eng_run_o <= 1'b1;
                        frm       <= (state == S_ADDR_RUN) ? addr_frame(req)
                                                           : data_frame(req);
                    end
                end
                S_ADDR_WAIT: begin
                    if (eng_busy_i) begin
                        busy_seen <= 1'b1;
                    end
                    if (busy_fell) begin
                        if (req.op == COP_ADDR) begin
                            state       <= S_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_DATA_RUN;
                        if (!eng_busy_i) begin
                            eng_run_o <= 1'b1;
                            frm       <= data_frame(req);
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DATA_WAIT: begin
                    if (eng_busy_i) begin
                        busy_seen <= 1'b1;
                    end
                    if (busy_fell) begin
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= req.op[1] ? eng_data_i : 16'h0000;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
